// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared port IDs, status bit positions and frame-state encoding
// Rev 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_DATA   = 8'd3;
    localparam logic [7:0] PS2_STATUS = 8'd13;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_FERR   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ============================================================================
// ps2_byte_fifo : byte FIFO with registered empty/full and dropped-push report
// Rev 1.0
// ============================================================================
module ps2_byte_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       drop
);

    localparam int                 DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_nxt;
    logic               do_push;
    logic               do_pop;

    // A pop frees a slot in the same edge, so a push at full still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + CNT_ONE;
        else if (!do_push && do_pop)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// ps2_keyboard_rx : PS/2 keyboard deframer with scan-code FIFO and PicoBlaze read ports
// Rev 1.0
// ============================================================================
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter logic [7:0] DATA_PORT   = PS2_DATA,
    parameter logic [7:0] STATUS_PORT = PS2_STATUS,
    parameter int         FIFO_AW     = 2,
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       DATA_IN,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam int            TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic                  ps2c_meta, ps2c_sync;
    logic                  data_meta, data_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  fclk;
    logic                  fall;

    frame_state_t          state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TO_W-1:0]       to_cnt;

    logic                  frame_ok, push, frame_bad, pop, stat_rd;
    logic                  overflow, frame_err;
    logic [7:0]            fifo_dout;
    logic                  fifo_empty, fifo_full, fifo_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_meta <= 1'b1;
            ps2c_sync <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            filt_sr   <= '1;
            fclk      <= 1'b1;
        end else begin
            ps2c_meta <= ps2c;
            ps2c_sync <= ps2c_meta;
            data_meta <= DATA_IN;
            data_sync <= data_meta;
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], ps2c_sync};
            if (&filt_sr)
                fclk <= 1'b1;
            else if (~|filt_sr)
                fclk <= 1'b0;
        end
    end

    // High for exactly the cycle in which fclk is about to drop.
    assign fall = fclk & ~|filt_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else if (fall) begin
            to_cnt <= '0;
            case (state)
                IDLE: begin
                    if (!data_sync) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    shreg   <= {data_sync, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: begin
                    par_bit <= data_sync;
                    state   <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
                state  <= IDLE;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_ONE;
            end
        end
    end

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign frame_ok  = data_sync & (^{shreg, par_bit});
    assign push      = fall & (state == STOP) & frame_ok;
    assign frame_bad = fall & (state == STOP) & ~frame_ok;
    assign pop       = read_strobe & (port_id == DATA_PORT);
    assign stat_rd   = read_strobe & (port_id == STATUS_PORT);

    ps2_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    // A new error on the clearing edge takes priority over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= fifo_drop | (overflow & ~stat_rd);
            frame_err <= frame_bad | (frame_err & ~stat_rd);
        end
    end

    assign irq = ~fifo_empty;

    always_comb begin
        data_out = 8'h00;
        if (port_id == DATA_PORT) begin
            if (!fifo_empty) data_out = fifo_dout;
        end else if (port_id == STATUS_PORT) begin
            data_out[ST_NEMPTY] = ~fifo_empty;
            data_out[ST_FULL]   = fifo_full;
            data_out[ST_OVF]    = overflow;
            data_out[ST_FERR]   = frame_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// tb_ps2_keyboard_rx : scoreboard bench driving PS/2 frames and processor reads
// Rev 1.0
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam logic [7:0] DATA_P = 8'd3;
    localparam logic [7:0] STAT_P = 8'd13;
    localparam int         HALF   = 40;
    localparam int         TO_CYC = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       DATA_IN;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] data_out;
    logic       irq;

    typedef struct {
        logic [7:0] data;
        logic       irq;
        logic [7:0] port;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] mq [$];
    bit         m_ovf = 1'b0;
    bit         m_ferr = 1'b0;
    bit         done = 1'b0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .DATA_PORT   (DATA_P),
        .STATUS_PORT (STAT_P),
        .FIFO_AW     (2),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .DATA_IN     (DATA_IN),
        .port_id     (port_id),
        .read_strobe (read_strobe),
        .data_out    (data_out),
        .irq         (irq)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model of one processor read; called one step after a rising edge.
    task automatic rd(input logic [7:0] pid);
        exp_t e;
        e.port = pid;
        e.irq  = (mq.size() != 0);
        e.data = 8'h00;
        if (pid == DATA_P) begin
            if (mq.size() != 0) begin
                e.data = mq[0];
                void'(mq.pop_front());
            end
        end else if (pid == STAT_P) begin
            e.data = {4'b0000, m_ferr, m_ovf, mq.size() == 4, mq.size() != 0};
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
        end
        exp_q.push_back(e);
        port_id     = pid;
        read_strobe = 1'b1;
        wait_cyc(1);
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                              input int glitch_bit, input bit pop_at_stop);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            DATA_IN = f[i];
            if (i == glitch_bit) begin
                wait_cyc(10);
                ps2c = 1'b0;
                wait_cyc(3);
                ps2c = 1'b1;
                wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2c = 1'b0;
            // Two sync flops plus eight filter stages put the stop-bit push 11 edges out.
            if (pop_at_stop && i == 10) begin
                wait_cyc(10);
                rd(DATA_P);
                wait_cyc(HALF - 11);
            end else begin
                wait_cyc(HALF);
            end
            ps2c = 1'b1;
        end
        DATA_IN = 1'b1;
        wait_cyc(2 * HALF);
        if (nbits == 11) begin
            if (bad_par)
                m_ferr = 1'b1;
            else if (mq.size() < 4)
                mq.push_back(d);
            else
                m_ovf = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] others [4];
        others = '{8'h00, 8'h01, 8'h0C, 8'hFF};
        reset       = 1'b0;
        ps2c        = 1'b1;
        DATA_IN     = 1'b1;
        port_id     = 8'h00;
        read_strobe = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);
        rd(STAT_P);
        rd(DATA_P);
        rd(8'h07);

        send_frame(8'h1C, 1'b0, 11, -1, 1'b0);
        rd(STAT_P);
        rd(DATA_P);
        rd(STAT_P);

        send_frame(8'h1C, 1'b1, 11, -1, 1'b0);
        rd(STAT_P);
        rd(STAT_P);
        rd(DATA_P);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 11, -1, 1'b0);
        rd(STAT_P);
        for (int i = 0; i < 4; i++) rd(DATA_P);
        rd(STAT_P);
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 11, -1, 1'b0);
        rd(STAT_P);
        send_frame(8'h15, 1'b0, 11, -1, 1'b1);
        rd(STAT_P);
        for (int i = 0; i < 4; i++) rd(DATA_P);
        rd(STAT_P);

        send_frame(8'hA5, 1'b0, 5, -1, 1'b0);
        wait_cyc(TO_CYC + 500);
        send_frame(8'hF0, 1'b0, 11, -1, 1'b0);
        rd(STAT_P);
        rd(DATA_P);
        rd(STAT_P);

        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(20);
        send_frame(8'h5A, 1'b0, 11, 3, 1'b1);
        rd(STAT_P);
        rd(DATA_P);

        send_frame(8'h33, 1'b0, 11, -1, 1'b0);
        send_frame(8'h77, 1'b0, 4, -1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        rd(STAT_P);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(20);
        send_frame(8'h29, 1'b0, 11, -1, 1'b0);
        rd(STAT_P);
        rd(DATA_P);

        for (int n = 0; n < 10; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), 11, -1, 1'b0);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                case ($urandom_range(0, 2))
                    0:       rd(DATA_P);
                    1:       rd(STAT_P);
                    default: rd(others[$urandom_range(0, 3)]);
                endcase
            end
        end
        rd(STAT_P);
        for (int i = 0; i < 5; i++) rd(DATA_P);
        wait_cyc(2);
        done = 1'b1;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (read_strobe) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected port=%0d got=%h", port_id, data_out);
                end else begin
                    e = exp_q.pop_front();
                    tests++;
                    if (data_out !== e.data) begin
                        fails++;
                        $display("FAIL rd_data port=%0d got=%h exp=%h", e.port, data_out, e.data);
                    end
                    tests++;
                    if (irq !== e.irq) begin
                        fails++;
                        $display("FAIL irq port=%0d got=%b exp=%b", e.port, irq, e.irq);
                    end
                end
            end
            if (done) begin
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the PicoBlaze input multiplexer. It filters the keyboard clock, deframes 11-bit PS/2 frames and buffers scan codes in a small FIFO. It exposes a data port and a status port on the processor's port_id/read_strobe bus. The top-level in_port mux routes its data_out for the data and status port IDs.

Parameters:
DATA_PORT, 8'd3, port_id that returns the FIFO head byte and pops it on read_strobe
STATUS_PORT, 8'd13, port_id that returns the status byte
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4
FILTER_LEN, 8, ps2c glitch-filter length in clk cycles
TIMEOUT_CYC, 100000, idle clk cycles mid-frame before the frame is aborted (1 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ps2c  in  1  raw PS/2 clock from the keyboard
DATA_IN  in  1  raw PS/2 data from the keyboard
port_id  in  8  PicoBlaze port_id
read_strobe  in  1  PicoBlaze read_strobe
data_out  out  8  combinational read data to the in_port mux
irq  out  1  registered; high while the FIFO is not empty

Behaviour:
- Reset (reset=0, async) clears all of the following. Outputs: irq=0; data_out=0 unless an addressed read selects status (then 0x00).
  - synchronizers to 1, filter to all-ones, filtered clock to 1
  - frame state IDLE, bit count 0, timeout counter 0
  - FIFO pointers 0, sticky flags 0
- Input conditioning:
  - ps2c and DATA_IN each pass through a 2-flop synchronizer.
  - Synchronized ps2c shifts into a FILTER_LEN shift register.
  - Filtered clock goes to 1 only when the register is all ones and to 0 only when it is all zeros; otherwise it holds.
  - A fall event is a single-cycle pulse on the filtered clock's 1->0 transition.
- Frame FSM, advanced only on fall events:
  - IDLE: if sampled data=0 (start bit), go to DATA with count=0. Data=1 is ignored.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: frame is valid iff stop=1 and XOR(data[7:0], parity)=1 (odd parity).
    - Valid: push the byte in the same cycle.
    - Invalid: set frame_err and discard the byte.
    - In both cases, return to IDLE.
- Timeout:
  - The counter runs in every non-IDLE state and is cleared on each fall event.
  - Reaching TIMEOUT_CYC-1 forces IDLE and discards the partial frame; no error flag is set.
- FIFO:
  - A pushed byte is visible (irq=1, status bit0=1) on the cycle after the push edge.
  - Pop occurs at the edge where read_strobe=1, port_id=DATA_PORT and the FIFO is not empty.
  - Push while full with no pop: drop the incoming byte and set overflow.
  - Simultaneous push and pop while full: both proceed, no overflow.
  - Simultaneous push and pop while empty: push only; the pop is ignored.
  - Pointers wrap modulo depth.
- Read data (combinational, all 8 bits of the value below):
  - port_id=DATA_PORT: FIFO head, or 0x00 if empty.
  - port_id=STATUS_PORT: {4'b0, frame_err, overflow, full, ~empty}.
  - Any other port_id: 0x00.
- Status read side effect: read_strobe with port_id=STATUS_PORT clears overflow and frame_err at that edge. If a new error occurs on the same edge, set wins.
- Reset mid-frame: the frame is lost. Reception restarts at the next start bit after the filter settles.

Decomposition:
- Shared package ps2_pkg holds:
  - port IDs PS2_DATA=3 and PS2_STATUS=13, identical to the top-level constants
  - status bit positions ST_NEMPTY=0, ST_FULL=1, ST_OVF=2, ST_FERR=3
  - frame-state encoding IDLE/DATA/PARITY/STOP
- One sub-module, ps2_byte_fifo: synchronous FIFO, parameter FIFO_AW, with push, pop, din, dout, empty and full. It handles the push/pop-while-full rule internally and reports the dropped push to the parent.

Test Plan:
1. Send a valid frame for 0x1C (parity=0, stop=1) at a 60 us bit period -> irq=1. Status read = 0x01. Data read = 0x1C, then irq=0 and status = 0x00.
2. Send 0x1C with parity=1 -> FIFO stays empty, status = 0x08. A second status read returns 0x00.
3. Send 5 valid frames 0x01..0x05 with no reads -> status = 0x07. Then four data reads return 0x01, 0x02, 0x03, 0x04, and status = 0x00. Also cover pop and push in the same cycle at full -> no overflow, order preserved.
4. Send a start bit plus 4 data bits, idle for more than TIMEOUT_CYC, then a valid frame for 0xF0 -> exactly one byte, 0xF0, and status = 0x01.
5. Apply 3-cycle low glitches on ps2c during IDLE and DATA -> no state change, then a clean 0x5A frame is received correctly.
6. Assert reset low mid-frame, asynchronously between clk edges -> irq=0 and status = 0x00 immediately. The next full frame for 0x29 is received.
